// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/long-press/auto-repeat strobes,
// plus a held flag and a wrapping press counter. All outputs registered.
module key_event_decoder #(
    parameter bit KEY_ACTIVE_LOW    = 1'b1,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000,
    parameter int CNT_W             = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             key_i,
    output logic             press_stb_o,
    output logic             release_stb_o,
    output logic             long_press_stb_o,
    output logic             repeat_stb_o,
    output logic             hold_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int MAX_C = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam bit REP_EN = (REPEAT_CYCLES != 0);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pressed, pressed_q, rise, fall;
    logic            press_d, release_d, long_d, repeat_d;
    logic [CNT_W-1:0] press_cnt_d;

    assign pressed = key_i ^ KEY_ACTIVE_LOW;
    assign rise    = pressed & ~pressed_q;
    assign fall    = ~pressed & pressed_q;

    // Sampled through reset so a key held across reset never looks like a new press.
    always_ff @(posedge clk_i) begin
        pressed_q <= pressed;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            press_cnt_o      <= '0;
            press_stb_o      <= 1'b0;
            release_stb_o    <= 1'b0;
            long_press_stb_o <= 1'b0;
            repeat_stb_o     <= 1'b0;
            hold_o           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            press_cnt_o      <= press_cnt_d;
            press_stb_o      <= press_d;
            release_stb_o    <= release_d;
            long_press_stb_o <= long_d;
            repeat_stb_o     <= repeat_d;
            hold_o           <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (REP_EN) begin
                    cnt_d = (cnt_q == REP_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A release on the same edge as a threshold suppresses the long/repeat strobe.
    always_comb begin
        press_d     = (state_q == IDLE) & rise;
        release_d   = (state_q != IDLE) & fall;
        long_d      = (state_q == PRESSED) & ~fall & (cnt_q == LONG_LAST);
        repeat_d    = REP_EN & (state_q == HELD) & ~fall & (cnt_q == REP_LAST);
        press_cnt_d = press_cnt_o + CNT_W'(press_d);
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: per-cycle strobe masks for each scenario,
// LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4, active-low key, 2-bit press counter.
module tb_key_event_decoder;

    logic       clk_i = 1'b0;
    logic       srst_i;
    logic       key_i;
    logic       press_stb_o, release_stb_o, long_press_stb_o, repeat_stb_o, hold_o;
    logic [1:0] press_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    key_event_decoder #(
        .KEY_ACTIVE_LOW(1'b1), .LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(2)
    ) dut (
        .clk_i(clk_i), .srst_i(srst_i), .key_i(key_i),
        .press_stb_o(press_stb_o), .release_stb_o(release_stb_o),
        .long_press_stb_o(long_press_stb_o), .repeat_stb_o(repeat_stb_o),
        .hold_o(hold_o), .press_cnt_o(press_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic p, input logic r, input logic l,
                            input logic rp, input logic h);
        chk({tag, ".press"},   32'(press_stb_o),      32'(p));
        chk({tag, ".release"}, 32'(release_stb_o),    32'(r));
        chk({tag, ".long"},    32'(long_press_stb_o), 32'(l));
        chk({tag, ".repeat"},  32'(repeat_stb_o),     32'(rp));
        chk({tag, ".hold"},    32'(hold_o),           32'(h));
    endtask

    // Key goes low now; released after low_len ticks. Bit i of each mask = expected in tick i.
    task automatic run_press(input string tag, input int low_len, input int nticks,
                             input logic [31:0] pm, input logic [31:0] lm, input logic [31:0] rpm,
                             input logic [31:0] rlm, input logic [31:0] hm, input logic [1:0] cnt_exp);
        key_i = 1'b0;
        for (int i = 1; i <= nticks; i++) begin
            tick();
            if (i == low_len) key_i = 1'b1;
            chk_outs($sformatf("%s.t%0d", tag, i), pm[i], rlm[i], lm[i], rpm[i], hm[i]);
        end
        chk({tag, ".cnt"}, 32'(press_cnt_o), 32'(cnt_exp));
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        tick();
        tick();
        srst_i = 1'b0;
    endtask

    initial begin
        srst_i = 1'b1;
        key_i  = 1'b1;
        tick();
        tick();
        chk_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", 32'(press_cnt_o), 32'd0);
        srst_i = 1'b0;
        tick();

        // short press, 5 cycles low
        run_press("short", 5, 8, 32'h2, 32'h0, 32'h0, 32'h40, 32'h3E, 2'd1);
        // long press with repeat; release edge coincides with third repeat threshold
        run_press("long", 20, 23, 32'h2, 32'h200, 32'h22000, 32'h200000, 32'h1FFFFE, 2'd2);
        // release on the long-press threshold edge
        run_press("coin", 8, 11, 32'h2, 32'h0, 32'h0, 32'h200, 32'h1FE, 2'd3);

        // wrap of the 2-bit press counter
        do_reset();
        tick();
        run_press("wrap1", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd1);
        run_press("wrap2", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd2);
        run_press("wrap3", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd3);
        run_press("wrap4", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd0);
        run_press("wrap5", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd1);

        // key held through reset: no press, and no release when let go
        key_i = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_outs($sformatf("thru.hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        key_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs($sformatf("thru.rel%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("thru.cnt0", 32'(press_cnt_o), 32'd0);
        run_press("thru.next", 3, 5, 32'h2, 32'h0, 32'h0, 32'h10, 32'hE, 2'd1);

        // reset pulse while in HELD
        key_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid.hold_before", 32'(hold_o), 32'd1);
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        chk_outs("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid.cnt", 32'(press_cnt_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_outs($sformatf("mid.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        key_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs($sformatf("mid.rel%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
